// File: rtl/alu_bit_cells.sv
// Registered front-end bundle of the ALU's 1-bit cells: half adder, full adder and
// 3-to-8 decoder share the same inputs; all results appear together one clock later.
module alu_bit_cells #(
  parameter bit DEC_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       dec_en,
  output logic       out_valid,
  output logic       ha_s,
  output logic       ha_c,
  output logic       fa_s,
  output logic       fa_c,
  output logic [7:0] dec_out
);

  // Decoder pattern with no line selected, in the configured polarity.
  localparam logic [7:0] DEC_IDLE = DEC_ACTIVE_HIGH ? 8'h00 : 8'hFF;

  logic       w_ha_s;
  logic       w_ha_c;
  logic       w_fa_s;
  logic       w_fa_c;
  logic [2:0] w_dec_idx;
  logic [7:0] w_dec_hot;
  logic [7:0] w_dec_line;

  logic       r_out_valid;
  logic       r_ha_s;
  logic       r_ha_c;
  logic       r_fa_s;
  logic       r_fa_c;
  logic [7:0] r_dec_out;

  assign w_ha_s    = a ^ b;
  assign w_ha_c    = a & b;
  assign w_fa_s    = a ^ b ^ cin;
  assign w_fa_c    = (a & b) | (a & cin) | (b & cin);
  assign w_dec_idx = {a, b, cin};

  always_comb begin
    // NOTE: default every bit first so no path through this block can infer a latch.
    w_dec_hot = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_dec_hot[i] = dec_en && (w_dec_idx == 3'(i));
    end
  end

  assign w_dec_line = DEC_ACTIVE_HIGH ? w_dec_hot : ~w_dec_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ha_s      <= 1'b0;
      r_ha_c      <= 1'b0;
      r_fa_s      <= 1'b0;
      r_fa_c      <= 1'b0;
      r_dec_out   <= DEC_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_ha_s    <= w_ha_s;
        r_ha_c    <= w_ha_c;
        r_fa_s    <= w_fa_s;
        r_fa_c    <= w_fa_c;
        r_dec_out <= w_dec_line;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign ha_s      = r_ha_s;
  assign ha_c      = r_ha_c;
  assign fa_s      = r_fa_s;
  assign fa_c      = r_fa_c;
  assign dec_out   = r_dec_out;

endmodule

// File: tb/tb_alu_bit_cells.sv
// Directed self-checking bench for alu_bit_cells (active-high decoder configuration).
module tb_alu_bit_cells;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a;
  logic       b;
  logic       cin;
  logic       dec_en;
  logic       out_valid;
  logic       ha_s;
  logic       ha_c;
  logic       fa_s;
  logic       fa_c;
  logic [7:0] dec_out;

  int tests_run;
  int tests_failed;

  alu_bit_cells #(.DEC_ACTIVE_HIGH(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .dec_en   (dec_en),
    .out_valid(out_valid),
    .ha_s     (ha_s),
    .ha_c     (ha_c),
    .fa_s     (fa_s),
    .fa_c     (fa_c),
    .dec_out  (dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {out_valid, ha_c, ha_s, fa_c, fa_s, dec_out}
  function automatic logic [12:0] observed();
    return {out_valid, ha_c, ha_s, fa_c, fa_s, dec_out};
  endfunction

  // Present inputs on the falling edge, then step past the next rising edge.
  task automatic drive(input logic va, input logic vb, input logic vc,
                       input logic ven, input logic vvalid);
    @(negedge clk);
    a        = va;
    b        = vb;
    cin      = vc;
    dec_en   = ven;
    in_valid = vvalid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 1'b1;
    b        = 1'b1;
    cin      = 1'b1;
    dec_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== 13'h0_00) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", observed(), 13'h0_00);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== 13'h0_00) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b expected %b", observed(), 13'h0_00);
    end
  endtask

  task automatic test_cin0_sweep();
    logic [1:0]  ab  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [12:0] exp [4] = '{
      {1'b1, 2'b00, 2'b00, 8'b0000_0001},
      {1'b1, 2'b01, 2'b01, 8'b0001_0000},
      {1'b1, 2'b01, 2'b01, 8'b0000_0100},
      {1'b1, 2'b10, 2'b10, 8'b0100_0000}};
    for (int i = 0; i < 4; i++) begin
      drive(ab[i][1], ab[i][0], 1'b0, 1'b1, 1'b1);
      tests_run++;
      if (observed() !== exp[i]) begin
        tests_failed++;
        $display("FAIL cin0_ab%b: got %b expected %b", ab[i], observed(), exp[i]);
      end
    end
  endtask

  task automatic test_cin1_sweep();
    logic [1:0]  ab  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [12:0] exp [4] = '{
      {1'b1, 2'b00, 2'b01, 8'b0000_0010},
      {1'b1, 2'b01, 2'b10, 8'b0010_0000},
      {1'b1, 2'b01, 2'b10, 8'b0000_1000},
      {1'b1, 2'b10, 2'b11, 8'b1000_0000}};
    for (int i = 0; i < 4; i++) begin
      drive(ab[i][1], ab[i][0], 1'b1, 1'b1, 1'b1);
      tests_run++;
      if (observed() !== exp[i]) begin
        tests_failed++;
        $display("FAIL cin1_ab%b: got %b expected %b", ab[i], observed(), exp[i]);
      end
    end
  endtask

  task automatic test_dec_disable();
    logic [12:0] exp;
    exp = {1'b1, 2'b10, 2'b11, 8'h00};
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL dec_disable: got %b expected %b", observed(), exp);
    end
  endtask

  task automatic test_hold();
    logic [12:0] exp;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp = {1'b1, 2'b10, 2'b10, 8'b0100_0000};
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL hold_capture: got %b expected %b", observed(), exp);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp = {1'b0, 2'b10, 2'b10, 8'b0100_0000};
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL hold_idle: got %b expected %b", observed(), exp);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp = {1'b1, 2'b00, 2'b00, 8'b0000_0001};
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL hold_resume: got %b expected %b", observed(), exp);
    end
  endtask

  task automatic test_back_to_back_exhaustive();
    logic [2:0] idx;
    logic [1:0] sum;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      sum = 2'(idx[2]) + 2'(idx[1]) + 2'(idx[0]);
      drive(idx[2], idx[1], idx[0], 1'b1, 1'b1);
      tests_run++;
      if ($countones(dec_out) != 1 || dec_out[idx] !== 1'b1 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL exh_dec_%0d: got dec=%b valid=%b expected one-hot bit %0d",
                 i, dec_out, out_valid, i);
      end
      tests_run++;
      if ({fa_c, fa_s} !== sum) begin
        tests_failed++;
        $display("FAIL exh_fa_%0d: got %b expected %b", i, {fa_c, fa_s}, sum);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    logic [12:0] exp;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    exp = {1'b1, 2'b01, 2'b10, 8'b0010_0000};
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: got %b expected %b", observed(), exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (observed() !== 13'h0_00) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got %b expected %b", observed(), 13'h0_00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp = {1'b1, 2'b01, 2'b10, 8'b0000_1000};
    tests_run++;
    if (observed() !== exp) begin
      tests_failed++;
      $display("FAIL post_reset_capture: got %b expected %b", observed(), exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_cin0_sweep();
    test_cin1_sweep();
    test_dec_disable();
    test_hold();
    test_back_to_back_exhaustive();
    test_async_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
